snake_obstacle_field: RTL and testbench

//  - Obstacle manager for the snake game. Spawns up to NUM_OBS square obstacles at pseudo-random grid positions.
//  - Exposes all obstacle rectangles as one packed bus for the renderer.
//  - Flags a collision (stop) when the snake head rectangle overlaps any active obstacle.
//  - Sits between the game controller (inc, head) and the VGA draw/game-over logic.

---
 rtl/snake_obstacle_field.sv | 104 ++++++++++
 tb/tb_snake_obstacle_field.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/snake_obstacle_field.sv
// Obstacle manager: LFSR-placed square obstacles plus sticky head-collision flag.
// Optional SNAKE_SPAWN_GUARD_EN drops candidates that would land on the current head.
package snake_obstacle_pkg;
    // Rect layout {xmin, ymin, xmax, ymax}, inclusive; touching edges overlap.
    function automatic logic rect_overlap(input logic [39:0] a, input logic [39:0] b);
        return (a[39:30] <= b[19:10]) && (b[39:30] <= a[19:10]) &&
               (a[29:20] <= b[9:0])   && (b[29:20] <= a[9:0]);
    endfunction
endpackage

module snake_obstacle_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [39:0] cand,
    input  logic [39:0] head,
    output logic [39:0] rect,
    output logic        hit
);
    import snake_obstacle_pkg::*;

    logic vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rect <= '0;
            vld  <= 1'b0;
        end else if (wr) begin
            rect <= cand;
            vld  <= 1'b1;
        end
    end

    // Only written slots take part, so the zeroed layout never collides.
    assign hit = vld && rect_overlap(rect, head);
endmodule

module snake_obstacle_field #(
    parameter int          NUM_OBS   = 100,
    parameter int          CELL      = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic [39:0]           head,
    output logic                  stop,
    output logic [40*NUM_OBS-1:0] obstacles
);
    import snake_obstacle_pkg::*;

    localparam int CW = $clog2(NUM_OBS + 1);

    logic [15:0]        lfsr;
    logic [CW-1:0]      count;
    logic [5:0]         xc;
    logic [4:0]         yc;
    logic [9:0]         xp;
    logic [9:0]         yp;
    logic [39:0]        cand;
    logic               spawn;
    logic [NUM_OBS-1:0] hits;

    always_comb begin
        xc   = (lfsr[5:0] >= 6'd40) ? lfsr[5:0] - 6'd24 : lfsr[5:0];
        yc   = (lfsr[10:6] >= 5'd30) ? lfsr[10:6] - 5'd16 : lfsr[10:6];
        xp   = 10'(xc) * 10'(CELL);
        yp   = 10'(yc) * 10'(CELL);
        cand = {xp, yp, xp + 10'(CELL - 1), yp + 10'(CELL - 1)};
    end

`ifdef SNAKE_SPAWN_GUARD_EN
    assign spawn = inc && !stop && (count < CW'(NUM_OBS)) && !rect_overlap(cand, head);
`else
    assign spawn = inc && !stop && (count < CW'(NUM_OBS));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            count <= '0;
            stop  <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (spawn)
                count <= count + 1'b1;
            // hits sees only pre-edge slots; a slot written now is tested next cycle
            if (|hits)
                stop <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_OBS; k++) begin : g_slot
        snake_obstacle_slot u_slot (
            .clk   (clk),
            .reset (reset),
            .wr    (spawn && (count == CW'(k))),
            .cand  (cand),
            .head  (head),
            .rect  (obstacles[40*k +: 40]),
            .hit   (hits[k])
        );
    end
endmodule

// File: tb/tb_snake_obstacle_field.sv
// Directed bench for snake_obstacle_field; expected rectangles are computed by hand or from a
// small LFSR/candidate model. Honors SNAKE_SPAWN_GUARD_EN for the spawn-on-head step.
module tb_snake_obstacle_field;
    localparam int          NUM_OBS = 100;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam logic [39:0] FAR     = {10'd1000, 10'd1000, 10'd1000, 10'd1000};

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  inc = 1'b0;
    logic [39:0]           head = FAR;
    logic                  stop;
    logic [40*NUM_OBS-1:0] obstacles;

    int tests = 0;
    int fails = 0;

    snake_obstacle_field #(.NUM_OBS(NUM_OBS), .CELL(16), .LFSR_SEED(SEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc),
        .head      (head),
        .stop      (stop),
        .obstacles (obstacles)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [39:0] cand_of(input logic [15:0] l);
        int x, y;
        x = int'(l[5:0]);
        if (x >= 40) x -= 24;
        y = int'(l[10:6]);
        if (y >= 30) y -= 16;
        return {10'(x * 16), 10'(y * 16), 10'(x * 16 + 15), 10'(y * 16 + 15)};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h, need %h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] slot(input int k);
        return obstacles[40*k +: 40];
    endfunction

    // advance one edge, then sample 1 time unit later
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this, the next rising edge sees lfsr == SEED.
    task automatic do_reset();
        reset = 1'b1;
        inc   = 1'b0;
        head  = FAR;
        step(1);
        reset = 1'b0;
    endtask

    logic [15:0] l;

    initial begin
        // reset state, then idle after release
        #1;
        chk("rst_bus_nz", {39'b0, |obstacles}, 40'd0);
        chk("rst_stop", {39'b0, stop}, 40'd0);
        step(1);
        reset = 1'b0;
        step(5);
        chk("idle_bus_nz", {39'b0, |obstacles}, 40'd0);
        chk("idle_stop", {39'b0, stop}, 40'd0);

        // first spawn from the seed
        do_reset();
        inc = 1'b1;
        step(1);
        inc = 1'b0;
        chk("spawn_slot0", slot(0), {10'd528, 10'd304, 10'd543, 10'd319});
        chk("spawn_slot1", slot(1), 40'd0);
        chk("spawn_slot99", slot(99), 40'd0);
        chk("spawn_stop", {39'b0, stop}, 40'd0);

        // collision is sticky and blocks spawns
        head = {10'd530, 10'd300, 10'd535, 10'd305};
        step(1);
        chk("hit_stop", {39'b0, stop}, 40'd1);
        head = FAR;
        step(1);
        chk("sticky_stop", {39'b0, stop}, 40'd1);
        inc = 1'b1;
        step(5);
        inc = 1'b0;
        chk("blocked_slot1", slot(1), 40'd0);
        chk("blocked_slot0", slot(0), {10'd528, 10'd304, 10'd543, 10'd319});

        // edge touching: x just past slot0 misses, shared column hits
        do_reset();
        inc = 1'b1;
        step(1);
        inc  = 1'b0;
        head = {10'd544, 10'd304, 10'd560, 10'd319};
        step(2);
        chk("adjacent_stop", {39'b0, stop}, 40'd0);
        head = {10'd543, 10'd310, 10'd550, 10'd312};
        step(1);
        chk("touch_stop", {39'b0, stop}, 40'd1);

        // spawn directly on the head
        do_reset();
        head = {10'd528, 10'd304, 10'd543, 10'd319};
        inc  = 1'b1;
        step(1);
`ifdef SNAKE_SPAWN_GUARD_EN
        chk("guard_slot0", slot(0), 40'd0);
        chk("guard_stop", {39'b0, stop}, 40'd0);
        step(1);
        inc = 1'b0;
        chk("guard_retry", slot(0), {10'd48, 10'd112, 10'd63, 10'd127});
        chk("guard_slot1", slot(1), 40'd0);
`else
        inc = 1'b0;
        chk("onhead_slot0", slot(0), {10'd528, 10'd304, 10'd543, 10'd319});
        chk("onhead_stop0", {39'b0, stop}, 40'd0);
        step(1);
        chk("onhead_stop1", {39'b0, stop}, 40'd1);
`endif

        // fill all slots, extra requests ignored
        do_reset();
        inc = 1'b1;
        step(120);
        inc = 1'b0;
        l = SEED;
        for (int k = 0; k < NUM_OBS; k++) begin
            chk($sformatf("fill_slot%0d", k), slot(k), cand_of(l));
            l = lfsr_next(l);
        end
        chk("fill_stop", {39'b0, stop}, 40'd0);

        // asynchronous reset between edges
        do_reset();
        inc = 1'b1;
        step(3);
        inc  = 1'b0;
        head = {10'd530, 10'd300, 10'd535, 10'd305};
        step(1);
        chk("pre_areset_stop", {39'b0, stop}, 40'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_bus_nz", {39'b0, |obstacles}, 40'd0);
        chk("areset_stop", {39'b0, stop}, 40'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
